// File: rtl/imem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// imem_port_arbiter_pkg
// Shared definitions for the instruction-memory port arbiter: controller
// state codes, the NOP returned for illegal fetches, the tag that records
// which requester owns the read in flight, and a fetch-legality helper.
// ---------------------------------------------------------------------------
package imem_port_arbiter_pkg;

    // Controller states (plain constants so older tools and dumps stay readable)
    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    // Instruction returned for a fetch that never touched memory
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Owner of the read whose data comes back next cycle
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    // A fetch is illegal if the byte address is not word aligned or lies
    // beyond the 2^addr_w-word memory.
    function automatic logic fetch_illegal(input logic [31:0] pc, input int unsigned addr_w);
        return (pc[1:0] != 2'b00) || ((pc >> (addr_w + 32'd2)) != 32'd0);
    endfunction

endpackage : imem_port_arbiter_pkg

// File: rtl/imem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// imem_port_arbiter_if
// Bundles every non-clock signal of the arbiter: loader stream, IF fetch,
// debug read, the single memory port and core status.
//   slave  : the arbiter itself
//   master : the surroundings (loader, fetch stage, debugger, memory)
// ---------------------------------------------------------------------------
interface imem_port_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    // Loader stream
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_start;
    // Fetch
    logic              if_req;
    logic [31:0]       if_pc;
    logic              if_stall;
    logic              if_valid;
    logic [DATA_W-1:0] if_instr;
    // Debug read
    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_gnt;
    logic              dbg_valid;
    logic [DATA_W-1:0] dbg_rdata;
    // Memory port
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    // Status
    logic              cpu_run;
    logic              fetch_err;
    logic [ADDR_W:0]   ld_count;

    modport slave (
        input  ld_valid, ld_addr, ld_data, ld_last, ld_start,
        input  if_req, if_pc, dbg_req, dbg_addr, mem_rdata,
        output ld_ready, if_stall, if_valid, if_instr,
        output dbg_gnt, dbg_valid, dbg_rdata,
        output mem_addr, mem_we, mem_wdata,
        output cpu_run, fetch_err, ld_count
    );

    modport master (
        output ld_valid, ld_addr, ld_data, ld_last, ld_start,
        output if_req, if_pc, dbg_req, dbg_addr, mem_rdata,
        input  ld_ready, if_stall, if_valid, if_instr,
        input  dbg_gnt, dbg_valid, dbg_rdata,
        input  mem_addr, mem_we, mem_wdata,
        input  cpu_run, fetch_err, ld_count
    );

endinterface : imem_port_arbiter_if

// File: rtl/imem_port_arbiter.sv
// ---------------------------------------------------------------------------
// imem_port_arbiter
// Owns the single port of the instruction memory and shares it between the
// boot loader (writes), the IF fetch (reads) and a debug read port.
// Sequences LOAD -> RUN, holds the core off while loading, drains one cycle
// on a reload request, and flags illegal fetches (sticky).
// Ports:
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : imem_port_arbiter_if.slave (loader, fetch, debug, memory, status)
// Grants, if_stall, dbg_gnt and the memory address/write strobes are
// combinational; read data returns one cycle after the grant.
// ---------------------------------------------------------------------------
module imem_port_arbiter
    import imem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter bit BOOT_LOAD  = 1'b1,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    imem_port_arbiter_if.slave bus
);

    localparam int          SW          = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [1:0]  RESET_STATE = BOOT_LOAD ? S_LOAD : S_RUN;
    localparam logic [ADDR_W:0] LD_MAX  = {1'b1, {ADDR_W{1'b0}}};

    logic [1:0]        state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    owner_e            owner_q, owner_d;
    logic              nop_q, nop_d;
    logic              fetch_err_q, fetch_err_d;
    logic [ADDR_W:0]   ld_count_q, ld_count_d;
    logic              cpu_run_q, cpu_run_d;

    logic              ld_fire_s;
    logic              illegal_s;
    logic              if_gnt_s;
    logic              dbg_gnt_s;
    logic [ADDR_W-1:0] mem_addr_s;

    // Read-port arbitration: fetch first unless debug has waited long enough
    always_comb begin
        ld_fire_s = (state_q == S_LOAD) && bus.ld_valid;
        illegal_s = fetch_illegal(bus.if_pc, ADDR_W);
        if_gnt_s  = 1'b0;
        dbg_gnt_s = 1'b0;
        if (state_q == S_RUN) begin
            if (bus.if_req && bus.dbg_req) begin
                if (starve_q >= STARVE_LIM) begin
                    dbg_gnt_s = 1'b1;
                end else begin
                    if_gnt_s = 1'b1;
                end
            end else if (bus.if_req) begin
                if_gnt_s = 1'b1;
            end else if (bus.dbg_req) begin
                dbg_gnt_s = 1'b1;
            end else begin
                if_gnt_s  = 1'b0;
                dbg_gnt_s = 1'b0;
            end
        end else begin
            if_gnt_s  = 1'b0;
            dbg_gnt_s = 1'b0;
        end
    end

    // Memory address mux; an illegal fetch is granted but leaves the port idle
    always_comb begin
        mem_addr_s = '0;
        case (state_q)
            S_LOAD: begin
                if (ld_fire_s) begin
                    mem_addr_s = bus.ld_addr;
                end else begin
                    mem_addr_s = '0;
                end
            end
            S_RUN: begin
                if (dbg_gnt_s) begin
                    mem_addr_s = bus.dbg_addr;
                end else if (if_gnt_s && !illegal_s) begin
                    mem_addr_s = bus.if_pc[ADDR_W+1:2];
                end else begin
                    mem_addr_s = '0;
                end
            end
            default: mem_addr_s = '0;
        endcase
    end

    // Controller sequencing and load word counter
    always_comb begin
        state_d    = state_q;
        ld_count_d = ld_count_q;
        case (state_q)
            S_LOAD: begin
                if (ld_fire_s) begin
                    if (ld_count_q != LD_MAX) begin
                        ld_count_d = ld_count_q + {{ADDR_W{1'b0}}, 1'b1};
                    end else begin
                        ld_count_d = ld_count_q;
                    end
                    if (bus.ld_last) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_RUN: begin
                if (bus.ld_start) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                // Counter is zeroed as the load phase is entered
                state_d    = S_LOAD;
                ld_count_d = '0;
            end
            default: begin
                state_d    = RESET_STATE;
                ld_count_d = '0;
            end
        endcase
        cpu_run_d = (state_d == S_RUN);
    end

    // Debug starvation counter, owner tag of the in-flight read, sticky error
    always_comb begin
        if ((state_q == S_RUN) && bus.dbg_req && !dbg_gnt_s) begin
            if (starve_q < STARVE_LIM) begin
                starve_d = starve_q + SW'(1);
            end else begin
                starve_d = starve_q;
            end
        end else begin
            starve_d = '0;
        end

        if (if_gnt_s) begin
            owner_d = OWN_IF;
        end else if (dbg_gnt_s) begin
            owner_d = OWN_DBG;
        end else begin
            owner_d = OWN_NONE;
        end

        nop_d       = if_gnt_s && illegal_s;
        fetch_err_d = fetch_err_q || (if_gnt_s && illegal_s);
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RESET_STATE;
            starve_q    <= '0;
            owner_q     <= OWN_NONE;
            nop_q       <= 1'b0;
            fetch_err_q <= 1'b0;
            ld_count_q  <= '0;
            cpu_run_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            owner_q     <= owner_d;
            nop_q       <= nop_d;
            fetch_err_q <= fetch_err_d;
            ld_count_q  <= ld_count_d;
            cpu_run_q   <= cpu_run_d;
        end
    end

    assign bus.ld_ready  = (state_q == S_LOAD);
    assign bus.if_stall  = bus.if_req && !if_gnt_s;
    assign bus.dbg_gnt   = dbg_gnt_s;
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_we    = ld_fire_s;
    assign bus.mem_wdata = ld_fire_s ? bus.ld_data : {DATA_W{1'b0}};

    // Returning data is steered by the owner tag captured at grant time
    assign bus.if_valid  = (owner_q == OWN_IF);
    assign bus.if_instr  = (owner_q == OWN_IF) ? (nop_q ? DATA_W'(NOP_INSTR) : bus.mem_rdata)
                                               : {DATA_W{1'b0}};
    assign bus.dbg_valid = (owner_q == OWN_DBG);
    assign bus.dbg_rdata = (owner_q == OWN_DBG) ? bus.mem_rdata : {DATA_W{1'b0}};

    assign bus.cpu_run   = cpu_run_q;
    assign bus.fetch_err = fetch_err_q;
    assign bus.ld_count  = ld_count_q;

endmodule : imem_port_arbiter
